// File: rtl/cache_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_ram_arbiter
// Purpose  : Shares the single cache-side RAM interface port between the
//            instruction cache (s0) and the data cache (s1). One request is
//            granted at a time, round-robin on contention; the read line and
//            the ack are returned only to the granted requester.
// Options  : define ARB_TIMEOUT_EN to build the GRANT watchdog
//            (TIMEOUT_CYCLES, 1..255), which completes a stuck request with
//            ack + err and a zeroed read line.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ram_arbiter #(
    parameter int ADDR_SIZE      = 13,
    parameter int CASH_STR_WIDTH = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      not_reset,
    // requester 0 (instruction cache)
    input  logic [ADDR_SIZE-1:0]      s0_addr,
    input  logic [CASH_STR_WIDTH-1:0] s0_wdata,
    input  logic                      s0_avalid,
    input  logic                      s0_rnw,
    output logic [CASH_STR_WIDTH-1:0] s0_rdata,
    output logic                      s0_ack,
    output logic                      s0_err,
    // requester 1 (data cache)
    input  logic [ADDR_SIZE-1:0]      s1_addr,
    input  logic [CASH_STR_WIDTH-1:0] s1_wdata,
    input  logic                      s1_avalid,
    input  logic                      s1_rnw,
    output logic [CASH_STR_WIDTH-1:0] s1_rdata,
    output logic                      s1_ack,
    output logic                      s1_err,
    // downstream RAM interface
    output logic [ADDR_SIZE-1:0]      m_addr,
    output logic [CASH_STR_WIDTH-1:0] m_wdata,
    output logic                      m_avalid,
    output logic                      m_rnw,
    input  logic [CASH_STR_WIDTH-1:0] m_rdata,
    input  logic                      m_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                    state_q,    state_d;
    // last_grant doubles as "current winner" while in GRANT/RESP
    logic                      last_grant_q, last_grant_d;
    logic [ADDR_SIZE-1:0]      m_addr_q,   m_addr_d;
    logic [CASH_STR_WIDTH-1:0] m_wdata_q,  m_wdata_d;
    logic                      m_rnw_q,    m_rnw_d;
    logic                      m_avalid_q, m_avalid_d;
    logic [CASH_STR_WIDTH-1:0] s0_rdata_q, s0_rdata_d;
    logic [CASH_STR_WIDTH-1:0] s1_rdata_q, s1_rdata_d;
    logic                      s0_ack_q,   s0_ack_d;
    logic                      s1_ack_q,   s1_ack_d;
    logic                      pick;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]                tmo_cnt_q,  tmo_cnt_d;
    logic                      s0_err_q,   s0_err_d;
    logic                      s1_err_q,   s1_err_d;
`endif

    // Next-state, arbitration and response logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_rnw_d      = m_rnw_q;
        m_avalid_d   = 1'b0;
        s0_rdata_d   = s0_rdata_q;
        s1_rdata_d   = s1_rdata_q;
        s0_ack_d     = 1'b0;
        s1_ack_d     = 1'b0;
        // on contention the requester that did not win last time goes next
        pick         = (s0_avalid && s1_avalid) ? ~last_grant_q : s1_avalid;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        s0_err_d     = 1'b0;
        s1_err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (s0_avalid || s1_avalid) begin
                    last_grant_d = pick;
                    m_addr_d     = pick ? s1_addr  : s0_addr;
                    m_wdata_d    = pick ? s1_wdata : s0_wdata;
                    m_rnw_d      = pick ? s1_rnw   : s0_rnw;
                    m_avalid_d   = 1'b1;
                    state_d      = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_d    = 8'd0;
`endif
                end
            end
            ST_GRANT: begin
                m_avalid_d = 1'b1;
                if (m_ack) begin
                    // a completion arriving with the timeout still wins
                    if (m_rnw_q) begin
                        if (last_grant_q) s1_rdata_d = m_rdata;
                        else              s0_rdata_d = m_rdata;
                    end
                    s0_ack_d   = ~last_grant_q;
                    s1_ack_d   = last_grant_q;
                    m_avalid_d = 1'b0;
                    state_d    = ST_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    if (last_grant_q) s1_rdata_d = '0;
                    else              s0_rdata_d = '0;
                    s0_ack_d   = ~last_grant_q;
                    s1_ack_d   = last_grant_q;
                    s0_err_d   = ~last_grant_q;
                    s1_err_d   = last_grant_q;
                    m_avalid_d = 1'b0;
                    state_d    = ST_RESP;
                end else begin
                    tmo_cnt_d  = tmo_cnt_q + 8'd1;
                end
`endif
            end
            ST_RESP: begin
                // requests are deliberately not sampled here
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_rnw_q      <= 1'b0;
            m_avalid_q   <= 1'b0;
            s0_rdata_q   <= '0;
            s1_rdata_q   <= '0;
            s0_ack_q     <= 1'b0;
            s1_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_rnw_q      <= m_rnw_d;
            m_avalid_q   <= m_avalid_d;
            s0_rdata_q   <= s0_rdata_d;
            s1_rdata_q   <= s1_rdata_d;
            s0_ack_q     <= s0_ack_d;
            s1_ack_q     <= s1_ack_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog counter and error pulse registers
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            tmo_cnt_q <= 8'd0;
            s0_err_q  <= 1'b0;
            s1_err_q  <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            s0_err_q  <= s0_err_d;
            s1_err_q  <= s1_err_d;
        end
    end

    assign s0_err = s0_err_q;
    assign s1_err = s1_err_q;
`else
    assign s0_err = 1'b0;
    assign s1_err = 1'b0;
`endif

    assign s0_rdata = s0_rdata_q;
    assign s1_rdata = s1_rdata_q;
    assign s0_ack   = s0_ack_q;
    assign s1_ack   = s1_ack_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_avalid = m_avalid_q;
    assign m_rnw    = m_rnw_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_ram_arbiter
// Purpose  : Self-checking bench for cache_ram_arbiter. The bench plays both
//            caches and the downstream RAM; a transaction-level model tracks
//            the round-robin winner and each requester's expected read line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_ram_arbiter;

    localparam int AW  = 13;
    localparam int DW  = 64;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          not_reset;
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic          req_av    [2];
    logic          req_rnw   [2];
    logic [DW-1:0] s_rdata   [2];
    logic          s_ack     [2];
    logic          s_err     [2];
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_avalid;
    logic          m_rnw;
    logic [DW-1:0] m_rdata;
    logic          m_ack;

    logic          last_g;
    logic [DW-1:0] rd_exp [2];
    int            n_assert = 0;
    int            n_fail   = 0;
    int            order [$];

    always #5 clk = ~clk;

    cache_ram_arbiter #(
        .ADDR_SIZE(AW), .CASH_STR_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .not_reset(not_reset),
        .s0_addr(req_addr[0]), .s0_wdata(req_wdata[0]), .s0_avalid(req_av[0]),
        .s0_rnw(req_rnw[0]), .s0_rdata(s_rdata[0]), .s0_ack(s_ack[0]), .s0_err(s_err[0]),
        .s1_addr(req_addr[1]), .s1_wdata(req_wdata[1]), .s1_avalid(req_av[1]),
        .s1_rnw(req_rnw[1]), .s1_rdata(s_rdata[1]), .s1_ack(s_ack[1]), .s1_err(s_err[1]),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_avalid(m_avalid), .m_rnw(m_rnw),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    task automatic pass();
        n_assert++;
    endtask

    task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int i, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic rnw);
        req_addr[i]  = a;
        req_wdata[i] = wd;
        req_rnw[i]   = rnw;
        req_av[i]    = 1'b1;
    endtask

    task automatic model_reset();
        last_g    = 1'b1;
        rd_exp[0] = '0;
        rd_exp[1] = '0;
    endtask

    function automatic int predict();
        if (req_av[0] && req_av[1]) return (last_g == 1'b0) ? 1 : 0;
        return req_av[0] ? 0 : 1;
    endfunction

    task automatic serve(input int lat, input logic [DW-1:0] rd, output int who);
        int w;
        int n;
        w = predict();
        n = 0;
        while (m_avalid !== 1'b1 && n < 6) begin
            tick();
            n++;
        end
        if (m_avalid !== 1'b1) fail("grant_seen", m_avalid, 1'b1); else pass();
        if (m_addr !== req_addr[w]) fail("m_addr", m_addr, req_addr[w]); else pass();
        if (m_rnw !== req_rnw[w]) fail("m_rnw", m_rnw, req_rnw[w]); else pass();
        if (m_wdata !== req_wdata[w]) fail("m_wdata", m_wdata, req_wdata[w]); else pass();
        last_g = w[0];
        for (int i = 0; i < lat; i++) begin
            tick();
            if (m_avalid !== 1'b1) fail("hold_avalid", m_avalid, 1'b1); else pass();
            if (m_addr !== req_addr[w]) fail("hold_addr", m_addr, req_addr[w]); else pass();
            if (m_wdata !== req_wdata[w]) fail("hold_wdata", m_wdata, req_wdata[w]); else pass();
            if (s_ack[w] !== 1'b0) fail("early_ack", s_ack[w], 1'b0); else pass();
        end
        m_ack   = 1'b1;
        m_rdata = rd;
        tick();
        m_ack   = 1'b0;
        m_rdata = {$urandom, $urandom};
        if (req_rnw[w]) rd_exp[w] = rd;
        if (s_ack[w] !== 1'b1) fail("ack_win", s_ack[w], 1'b1); else pass();
        if (s_ack[1-w] !== 1'b0) fail("ack_other", s_ack[1-w], 1'b0); else pass();
        if (s_err[w] !== 1'b0) fail("err_win", s_err[w], 1'b0); else pass();
        if (s_rdata[w] !== rd_exp[w]) fail("rdata_win", s_rdata[w], rd_exp[w]); else pass();
        if (s_rdata[1-w] !== rd_exp[1-w]) fail("rdata_other", s_rdata[1-w], rd_exp[1-w]); else pass();
        if (m_avalid !== 1'b0) fail("avalid_resp", m_avalid, 1'b0); else pass();
        req_av[w] = 1'b0;
        tick();
        if (s_ack[w] !== 1'b0) fail("ack_once", s_ack[w], 1'b0); else pass();
        who = w;
    endtask

    initial begin
        int who;
        logic [DW-1:0] v;
        not_reset = 1'b0;
        m_ack = 1'b0;
        m_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            req_addr[i] = '0; req_wdata[i] = '0; req_av[i] = 1'b0; req_rnw[i] = 1'b0;
        end
        model_reset();
        tick(); tick();
        if (m_avalid !== 1'b0) fail("rst_m_avalid", m_avalid, 1'b0); else pass();
        if (m_addr !== 13'h0) fail("rst_m_addr", m_addr, 13'h0); else pass();
        if (m_wdata !== 64'h0) fail("rst_m_wdata", m_wdata, 64'h0); else pass();
        if (s_ack[0] !== 1'b0) fail("rst_s0_ack", s_ack[0], 1'b0); else pass();
        if (s_rdata[1] !== 64'h0) fail("rst_s1_rdata", s_rdata[1], 64'h0); else pass();
        not_reset = 1'b1;
        tick();

        new_req(0, 13'h0A5, 64'h0, 1'b1);
        tick();
        if (m_avalid !== 1'b1) fail("lat1_avalid", m_avalid, 1'b1); else pass();
        serve(3, 64'h1122334455667788, who);
        if (who !== 0) fail("t1_who", who, 0); else pass();
        if (s_rdata[0] !== 64'h1122334455667788)
            fail("t1_s0_rdata", s_rdata[0], 64'h1122334455667788);
        else pass();

        for (int i = 0; i < 3; i++) begin
            m_ack = 1'b1; m_rdata = 64'hBAD0BAD0BAD0BAD0;
            tick();
            if (s_ack[0] !== 1'b0) fail("stray_s0_ack", s_ack[0], 1'b0); else pass();
            if (s_ack[1] !== 1'b0) fail("stray_s1_ack", s_ack[1], 1'b0); else pass();
            if (m_avalid !== 1'b0) fail("stray_avalid", m_avalid, 1'b0); else pass();
        end
        m_ack = 1'b0;

        new_req(1, 13'h1FFF, 64'hDEADBEEFCAFEF00D, 1'b0);
        tick();
        if (m_avalid !== 1'b1) fail("stray_idle_lat", m_avalid, 1'b1); else pass();
        serve(2, 64'h5555AAAA5555AAAA, who);
        if (who !== 1) fail("t2_who", who, 1); else pass();
        if (s_rdata[1] !== 64'h0) fail("t2_s1_rdata", s_rdata[1], 64'h0); else pass();

        not_reset = 1'b0;
        model_reset();
        tick();
        not_reset = 1'b1;
        new_req(0, 13'h0010, 64'h0, 1'b1);
        new_req(1, 13'h0020, 64'h0, 1'b1);
        order.delete();
        for (int t = 0; t < 4; t++) begin
            serve(1, {$urandom, $urandom}, who);
            order.push_back(who);
            new_req(who, 13'($urandom), {$urandom, $urandom}, 1'b1);
        end
        for (int t = 0; t < 4; t++) begin
            if (order[t] !== t % 2) fail("b2b_order", order[t], t % 2); else pass();
        end
        req_av[0] = 1'b0; req_av[1] = 1'b0;
        tick(); tick(); tick();
        if (m_avalid !== 1'b0) fail("b2b_drain", m_avalid, 1'b0); else pass();
        tick();

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 2; i++)
                if (!req_av[i] && $urandom_range(0, 1) == 1)
                    new_req(i, 13'($urandom), {$urandom, $urandom}, 1'($urandom));
            if (!req_av[0] && !req_av[1])
                new_req($urandom_range(0, 1), 13'($urandom), {$urandom, $urandom},
                        1'($urandom));
            serve($urandom_range(0, 3), {$urandom, $urandom}, who);
        end
        req_av[0] = 1'b0; req_av[1] = 1'b0;
        tick(); tick(); tick();

        new_req(0, 13'h0333, 64'h0, 1'b1);
        tick();
        if (m_avalid !== 1'b1) fail("pre_rst_avalid", m_avalid, 1'b1); else pass();
        #1 not_reset = 1'b0;
        #1;
        if (m_avalid !== 1'b0) fail("async_rst_avalid", m_avalid, 1'b0); else pass();
        if (s_rdata[1] !== 64'h0) fail("async_rst_rdata", s_rdata[1], 64'h0); else pass();
        req_av[0] = 1'b0;
        model_reset();
        tick();
        not_reset = 1'b1;
        tick();
        new_req(1, 13'h0444, 64'h0, 1'b1);
        serve(1, 64'h0F0F0F0F0F0F0F0F, who);
        if (who !== 1) fail("post_rst_who", who, 1); else pass();

        new_req(0, 13'h00AA, 64'h0, 1'b1);
`ifdef ARB_TIMEOUT_EN
        tick();
        if (m_avalid !== 1'b1) fail("tmo_grant", m_avalid, 1'b1); else pass();
        last_g = 1'b0;
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            if (s_ack[0] !== 1'b0) fail("tmo_early_ack", s_ack[0], 1'b0); else pass();
        end
        tick();
        if (s_ack[0] !== 1'b1) fail("tmo_ack", s_ack[0], 1'b1); else pass();
        if (s_err[0] !== 1'b1) fail("tmo_err", s_err[0], 1'b1); else pass();
        if (s_rdata[0] !== 64'h0) fail("tmo_rdata", s_rdata[0], 64'h0); else pass();
        if (m_avalid !== 1'b0) fail("tmo_avalid", m_avalid, 1'b0); else pass();
        rd_exp[0] = '0;
        req_av[0] = 1'b0;
        tick();
        if (s_err[0] !== 1'b0) fail("tmo_err_once", s_err[0], 1'b0); else pass();
        new_req(1, 13'h00BB, 64'h0, 1'b1);
        tick();
        last_g = 1'b1;
        for (int i = 0; i < TMO - 1; i++) tick();
        v = 64'hA5A5A5A55A5A5A5A;
        m_ack = 1'b1; m_rdata = v;
        tick();
        m_ack = 1'b0;
        if (s_ack[1] !== 1'b1) fail("race_ack", s_ack[1], 1'b1); else pass();
        if (s_err[1] !== 1'b0) fail("race_err", s_err[1], 1'b0); else pass();
        if (s_rdata[1] !== v) fail("race_rdata", s_rdata[1], v); else pass();
        req_av[1] = 1'b0;
        tick();
`else
        serve(TMO + 4, 64'h7777666655554444, who);
        if (who !== 0) fail("no_tmo_who", who, 0); else pass();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
